vga_frame_loader: RTL
=====================

# vga_frame_loader

Per-frame loader that copies both players' 128-bit sprite/position records from data memory into stable registers for the VGA controller. It sits between the processor's data-memory port and the memory/IO block and shares that single port between the processor and its own read engine. The processor has priority, with a starvation limit so the loader always finishes within the frame. New records are committed atomically, so the VGA side never sees a half-updated frame.

## Interface
Parameters:
- BASE_ADDR, 13'h1F00, word address of player-1 word 0; player 2 starts at BASE_ADDR+4
- STARVE_LIMIT, 8, maximum consecutive cycles the loader may be denied the port before it is forced a grant

Ports:
- clock  in  1  system clock; single clock domain
- reset_btn  in  1  synchronous, active-low reset
- vsync  in  1  VGA vertical sync, active-low, asynchronous to clock
- proc_req  in  1  processor is accessing dmem this cycle
- proc_addr  in  13  processor address
- proc_data  in  32  processor write data
- proc_wren  in  1  processor write enable
- proc_q  out  32  read data returned to processor (mem_q passthrough)
- proc_stall  out  1  processor access is not serviced this cycle
- mem_addr  out  13  address to memory/IO block
- mem_data  out  32  write data to memory/IO block
- mem_wren  out  1  write enable to memory/IO block
- mem_q  in  32  memory read data, valid one cycle after its address is presented
- p1VGA  out  128  committed player-1 record
- p2VGA  out  128  committed player-2 record
- busy  out  1  load in progress
- frame_done  out  1  one-cycle pulse on commit

## Operation
- vsync passes through a 2-flop synchronizer plus one edge flop. frame_start is the synchronized falling edge.
- FSM states: IDLE, LOAD, DRAIN, COMMIT.
  - IDLE: on frame_start, or if pending is set, go to LOAD. Clear idx (3 bits) and pending.
  - LOAD: the loader requests the port. On each grant it reads BASE_ADDR+idx and increments idx. After the grant with idx==7, go to DRAIN.
  - DRAIN: capture the last word, then go to COMMIT.
  - COMMIT: copy the shadow registers into p1VGA/p2VGA, assert frame_done, go to IDLE.
- Capture: the word granted in cycle t is taken from mem_q at the end of cycle t+1 into shadow word idx_at_grant.
  - Words 0–3 go to p1 shadow [32k+31:32k].
  - Words 4–7 go to p2 shadow [32(k-4)+31:32(k-4)].
- Grant rule: loader_grant = (state==LOAD) & (~proc_req | starve_cnt==STARVE_LIMIT).
- starve_cnt:
  - increments each LOAD cycle with proc_req=1 and no grant;
  - clears on any loader grant and in all other states;
  - saturates at STARVE_LIMIT.
- Port mux:
  - When loader_grant=1: mem_addr = loader address, mem_wren = 0, proc_stall = proc_req.
  - Otherwise: mem_addr = proc_addr, mem_data = proc_data, mem_wren = proc_req & proc_wren, proc_stall = 0.
- proc_q = mem_q at all times.
- frame_start while not in IDLE sets pending. Only one frame is queued; extra edges are dropped.
- Processor writes to the record region during LOAD are allowed. Each word reflects the memory value at that word's grant cycle.
- busy = (state != IDLE).

## Timing
- Reset (reset_btn=0 at a clock edge) sets:
  - state = IDLE; idx, starve_cnt, pending, shadows = 0;
  - p1VGA = p2VGA = 0; frame_done = 0;
  - synchronizer flops = 1 (vsync idle high).
- Reset during LOAD, DRAIN or COMMIT aborts the load with no partial commit.
- frame_start is asserted 3 cycles after vsync falls (synchronizer plus edge flop).
- Uncontended load, with frame_start in cycle T:
  - LOAD occupies T+1 to T+8 (8 grants);
  - DRAIN in T+9;
  - COMMIT in T+10, with frame_done=1;
  - new p1VGA/p2VGA values are visible from T+11.
- Worst case with proc_req held at 1: each word needs STARVE_LIMIT+1 cycles, so the load takes 8·(STARVE_LIMIT+1)+2 cycles after T.
- Mux outputs (mem_*, proc_stall, proc_q) are combinational from the current state and inputs. There is no added latency on processor accesses.

## Test plan
- Uncontended load: memory holds BASE+k = 32'hA0+k for k=0..7; drop vsync.
  -> frame_done once, 10 cycles after frame_start.
  -> p1VGA = {A3,A2,A1,A0}; p2VGA = {A7,A6,A5,A4}.
  -> mem_wren = 0 throughout.
- Starvation: proc_req=1 and proc_wren=1 continuously, STARVE_LIMIT=8.
  -> Loader is granted once every 9 cycles.
  -> proc_stall=1 and mem_wren=0 exactly in the grant cycles.
  -> frame_done 74 cycles after frame_start.
- Pending frame: a second vsync fall while busy=1.
  -> Exactly one extra load starts in the cycle after COMMIT.
  -> A third fall in the same window is dropped.
- Reset mid-load: assert reset_btn=0 in LOAD cycle 4 (p1VGA previously committed to nonzero).
  -> Next cycle busy=0 and p1VGA=0.
  -> No frame_done pulse.
- Passthrough: in IDLE, processor writes 32'hDEADBEEF to address 5 and then reads it.
  -> mem_addr=5, mem_wren=1, and proc_q = DEADBEEF one cycle after the read.
- Mid-load coherence: the processor writes BASE+6 = 32'h55 while the loader is at idx=2, processor-priority case.
  -> Committed p2VGA[95:64] = 32'h55.

Source files
------------

// File: rtl/vga_frame_loader.sv
// Per-frame loader: shares the dmem port with the processor (processor first, bounded
// starvation) and commits both 128-bit player records atomically for the VGA side.
module vga_frame_loader #(
  parameter logic [12:0] BASE_ADDR    = 13'h1F00,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic         clock,
  input  logic         reset_btn,
  input  logic         vsync,
  input  logic         proc_req,
  input  logic [12:0]  proc_addr,
  input  logic [31:0]  proc_data,
  input  logic         proc_wren,
  output logic [31:0]  proc_q,
  output logic         proc_stall,
  output logic [12:0]  mem_addr,
  output logic [31:0]  mem_data,
  output logic         mem_wren,
  input  logic [31:0]  mem_q,
  output logic [127:0] p1VGA,
  output logic [127:0] p2VGA,
  output logic         busy,
  output logic         frame_done
);
  localparam int            SW         = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_COMMIT} state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [SW-1:0]   r_starve;
  logic            r_pending;
  logic            r_vs_s1, r_vs_s2, r_vs_s3;
  logic            r_cap_vld;
  logic [2:0]      r_cap_idx;
  logic [127:0]    r_shadow1, r_shadow2;
  logic [127:0]    r_p1, r_p2;
  logic            r_frame_done;

  logic            w_frame_start;
  logic            w_grant;

  assign w_frame_start = r_vs_s3 & ~r_vs_s2;
  assign w_grant       = (r_state == S_LOAD) & (~proc_req | (r_starve == STARVE_MAX));

  always_comb begin
    mem_data   = proc_data;
    proc_q     = mem_q;
    if (w_grant) begin
      mem_addr   = BASE_ADDR + {10'd0, r_idx};
      mem_wren   = 1'b0;
      proc_stall = proc_req;
    end else begin
      mem_addr   = proc_addr;
      mem_wren   = proc_req & proc_wren;
      proc_stall = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_btn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_starve     <= '0;
      r_pending    <= 1'b0;
      r_vs_s1      <= 1'b1;
      r_vs_s2      <= 1'b1;
      r_vs_s3      <= 1'b1;
      r_cap_vld    <= 1'b0;
      r_cap_idx    <= '0;
      r_shadow1    <= '0;
      r_shadow2    <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_vs_s1      <= vsync;
      r_vs_s2      <= r_vs_s1;
      r_vs_s3      <= r_vs_s2;
      r_frame_done <= 1'b0;

      // Read data returns one cycle after the grant, so capture is a one-deep pipeline.
      r_cap_vld <= w_grant;
      r_cap_idx <= r_idx;
      if (r_cap_vld) begin
        if (r_cap_idx[2]) r_shadow2[{r_cap_idx[1:0], 5'd0} +: 32] <= mem_q;
        else              r_shadow1[{r_cap_idx[1:0], 5'd0} +: 32] <= mem_q;
      end

      if (w_frame_start && (r_state != S_IDLE)) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_idx     <= '0;
          r_starve  <= '0;
          r_pending <= 1'b0;
          if (w_frame_start || r_pending) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (w_grant) begin
            r_starve <= '0;
            r_idx    <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_DRAIN;
          end else if (proc_req && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
          end
        end
        S_DRAIN: begin
          r_starve     <= '0;
          r_frame_done <= 1'b1;
          r_state      <= S_COMMIT;
        end
        S_COMMIT: begin
          r_starve <= '0;
          r_p1     <= r_shadow1;
          r_p2     <= r_shadow2;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p1VGA      = r_p1;
  assign p2VGA      = r_p2;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
endmodule
